// File: rtl/mips_int_ctrl.sv
// Interrupt controller for the single-cycle MIPS core: synchronizes, latches and
// prioritizes N_SRC lines into one registered request. Optional build macro: INTC_LEVEL_EN.
module mips_int_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_SRC-1:0]  i_irq,
  input  logic              i_sel,
  input  logic              i_we,
  input  logic [1:0]        i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_ext_int,
  input  logic              i_ack,
  input  logic              i_eoi,
  output logic [ID_W-1:0]   o_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t           state_r;
  logic [N_SRC-1:0] s1_r, s2_r, s3_r;
  logic [N_SRC-1:0] pend_r, mask_r;
  logic [ID_W-1:0]  isr_id_r;
  logic [N_SRC-1:0] edge_s, req_s, w1c_s, ack_clr_s, clr_s, pend_nxt_s;
  logic [ID_W-1:0]  win_id_s;
  logic             any_s, wr_s, rd_s, ack_take_s;
  logic [31:0]      pend_word_s, mask_word_s, id_word_s, stat_word_s, addr3_word_s, rd_word_s;
  logic             unused_s;

`ifdef INTC_LEVEL_EN
  logic [N_SRC-1:0] trig_r;
  logic [31:0]      trig_word_s;
`endif

  assign edge_s     = s2_r & ~s3_r;
  assign req_s      = pend_r & mask_r;
  assign any_s      = |req_s;
  assign wr_s       = i_sel & i_we;
  assign rd_s       = i_sel & ~i_we;
  assign ack_take_s = (state_r == REQ) & i_ack & any_s;
  assign w1c_s      = (wr_s && (i_addr == 2'd0)) ? i_wdata[N_SRC-1:0] : {N_SRC{1'b0}};
  assign ack_clr_s  = ack_take_s ? (N_SRC'(1'b1) << win_id_s) : {N_SRC{1'b0}};
  assign clr_s      = w1c_s | ack_clr_s;
  assign unused_s   = ^i_wdata;

`ifdef INTC_LEVEL_EN
  // Level sources track the synchronized line; a clear only knocks the bit down for one cycle.
  assign pend_nxt_s = (trig_r & s2_r & ~clr_s) | (~trig_r & ((pend_r & ~clr_s) | edge_s));
`else
  assign pend_nxt_s = (pend_r & ~clr_s) | edge_s;
`endif

  // Lowest-index pending-and-enabled source wins.
  always_comb begin
    win_id_s = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        win_id_s = ID_W'(i);
      end else begin
        win_id_s = win_id_s;
      end
    end
  end

  // Input synchronizers, edge-detect flop, pending and software-visible registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_r   <= {N_SRC{1'b0}};
      s2_r   <= {N_SRC{1'b0}};
      s3_r   <= {N_SRC{1'b0}};
      pend_r <= {N_SRC{1'b0}};
      mask_r <= {N_SRC{1'b0}};
`ifdef INTC_LEVEL_EN
      trig_r <= {N_SRC{1'b0}};
`endif
    end else begin
      s1_r   <= i_irq;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      pend_r <= pend_nxt_s;
      if (wr_s && (i_addr == 2'd1)) begin
        mask_r <= i_wdata[N_SRC-1:0];
      end
`ifdef INTC_LEVEL_EN
      if (wr_s && (i_addr == 2'd3)) begin
        trig_r <= i_wdata[N_SRC-1:0];
      end
`endif
    end
  end

  // Request/service handshake with the core; request and ID outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      o_ext_int <= 1'b0;
      o_id      <= {ID_W{1'b0}};
      isr_id_r  <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r   <= REQ;
            o_ext_int <= 1'b1;
          end
        end
        REQ: begin
          if (ack_take_s) begin
            isr_id_r  <= win_id_s;
            o_id      <= win_id_s;
            o_ext_int <= 1'b0;
            state_r   <= SERVICE;
          end else if (!any_s) begin
            // Software cleared or masked the request before the core took it.
            o_ext_int <= 1'b0;
            state_r   <= IDLE;
          end
        end
        SERVICE: begin
          o_ext_int <= 1'b0;
          if (i_eoi) begin
            state_r <= IDLE;
          end
        end
        default: begin
          o_ext_int <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Register read mux; unimplemented upper bits read as zero.
  always_comb begin
    pend_word_s              = 32'd0;
    mask_word_s              = 32'd0;
    id_word_s                = 32'd0;
    stat_word_s              = 32'd0;
    pend_word_s[N_SRC-1:0]   = pend_r;
    mask_word_s[N_SRC-1:0]   = mask_r;
    id_word_s[31]            = any_s;
    id_word_s[ID_W-1:0]      = win_id_s;
    stat_word_s[1:0]         = state_r;
    stat_word_s[ID_W+7:8]    = isr_id_r;
`ifdef INTC_LEVEL_EN
    trig_word_s              = 32'd0;
    trig_word_s[N_SRC-1:0]   = trig_r;
    addr3_word_s             = {stat_word_s[15:0], 16'h0000} | trig_word_s;
`else
    addr3_word_s             = stat_word_s;
`endif
    case (i_addr)
      2'd0:    rd_word_s = pend_word_s;
      2'd1:    rd_word_s = mask_word_s;
      2'd2:    rd_word_s = id_word_s;
      2'd3:    rd_word_s = addr3_word_s;
      default: rd_word_s = 32'd0;
    endcase
    if (rd_s) begin
      o_rdata = rd_word_s;
    end else begin
      o_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Directed scoreboard bench for mips_int_ctrl: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_mips_int_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_irq;
  logic        i_sel, i_we;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ext_int;
  logic        i_ack, i_eoi;
  logic [4:0]  o_id;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rd_v;

  mips_int_ctrl #(.N_SRC(8), .ID_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_sel(i_sel), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ext_int(o_ext_int),
    .i_ack(i_ack), .i_eoi(i_eoi), .o_id(o_id)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] stat_word(input logic [1:0] st, input logic [4:0] isr);
    logic [31:0] w;
    w = {19'd0, isr, 6'd0, st};
`ifdef INTC_LEVEL_EN
    w = w << 16;
`endif
    return w;
  endfunction

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_v(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0x%08h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b0; i_addr = a;
    #1;
    d = o_rdata;
    i_sel = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    tick(1);
    i_sel = 1'b0; i_we = 1'b0; i_wdata = 32'd0;
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1; tick(1); i_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    i_eoi = 1'b1; tick(1); i_eoi = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    expect_v(tag, e);
    rd(a, rd_v);
    check_v(rd_v);
  endtask

  task automatic chk_ext(input string tag, input logic e);
    expect_v(tag, {31'd0, e});
    check_v({31'd0, o_ext_int});
  endtask

  task automatic chk_id(input string tag, input logic [4:0] e);
    expect_v(tag, {27'd0, e});
    check_v({27'd0, o_id});
  endtask

  initial begin
    i_rst_n = 1'b0; i_irq = 8'h00; i_sel = 1'b0; i_we = 1'b0; i_addr = 2'd0;
    i_wdata = 32'd0; i_ack = 1'b0; i_eoi = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);

    // 1: reset state
    chk_rd("rst_pend", 2'd0, 32'd0);
    chk_rd("rst_mask", 2'd1, 32'd0);
    chk_rd("rst_id",   2'd2, 32'd0);
    chk_rd("rst_stat", 2'd3, 32'd0);
    chk_ext("rst_ext", 1'b0);
    chk_id("rst_id_out", 5'd0);

    // 2: single source latency, ack, eoi
    wr(2'd1, 32'h0000_0004);
    i_irq = 8'h04;
    expect_v("t2_pend_edge3", 32'h0000_0004);
    tick(2);
    i_irq = 8'h00;
    tick(1);
    rd(2'd0, rd_v); check_v(rd_v);
    chk_ext("t2_ext_edge3", 1'b0);
    tick(1);
    chk_ext("t2_ext_edge4", 1'b1);
    chk_rd("t2_stat_req", 2'd3, stat_word(2'd1, 5'd0));
    pulse_ack();
    chk_id("t2_id", 5'd2);
    chk_rd("t2_pend_ack", 2'd0, 32'd0);
    chk_ext("t2_ext_ack", 1'b0);
    chk_rd("t2_stat_svc", 2'd3, stat_word(2'd2, 5'd2));
    pulse_eoi();
    chk_rd("t2_stat_eoi", 2'd3, stat_word(2'd0, 5'd2));

    // 3: priority between two simultaneous sources
    wr(2'd1, 32'h0000_00FF);
    i_irq = 8'h22;
    tick(3);
    chk_rd("t3_id_reg", 2'd2, 32'h8000_0001);
    expect_v("t3_rdata_unselected", 32'd0);
    #1; check_v(o_rdata);
    tick(1);
    chk_ext("t3_ext", 1'b1);
    pulse_ack();
    chk_id("t3_id_first", 5'd1);
    chk_rd("t3_pend_left", 2'd0, 32'h0000_0020);
    pulse_eoi();
    chk_ext("t3_ext_after_eoi", 1'b0);
    tick(1);
    chk_ext("t3_ext_rereq", 1'b1);
    pulse_ack();
    chk_id("t3_id_second", 5'd5);
    pulse_eoi();
    i_irq = 8'h00;

    // 4: new edge during service is held off until eoi
    i_irq = 8'h40;
    tick(4);
    chk_ext("t4_ext_src6", 1'b1);
    pulse_ack();
    chk_id("t4_id_src6", 5'd6);
    i_irq = 8'h08;
    tick(3);
    chk_rd("t4_pend_svc", 2'd0, 32'h0000_0008);
    chk_ext("t4_ext_svc", 1'b0);
    tick(2);
    chk_ext("t4_ext_svc_hold", 1'b0);
    pulse_eoi();
    chk_ext("t4_ext_eoi_edge", 1'b0);
    tick(1);
    chk_ext("t4_ext_rereq", 1'b1);
    pulse_ack();
    chk_id("t4_id_src3", 5'd3);
    pulse_eoi();
    i_irq = 8'h00;

    // 5: software clear while requesting, then clear racing an ack
    i_irq = 8'h10;
    tick(4);
    chk_ext("t5_ext_req", 1'b1);
    chk_rd("t5_stat_req", 2'd3, stat_word(2'd1, 5'd3));
    wr(2'd0, 32'h0000_0010);
    chk_rd("t5_pend_w1c", 2'd0, 32'd0);
    tick(1);
    chk_ext("t5_ext_drop", 1'b0);
    chk_rd("t5_stat_idle", 2'd3, stat_word(2'd0, 5'd3));
    i_irq = 8'h00;
    tick(3);
    i_irq = 8'h10;
    tick(4);
    chk_ext("t5_ext_req2", 1'b1);
    i_ack = 1'b1;
    wr(2'd0, 32'h0000_0010);
    i_ack = 1'b0;
    chk_id("t5_id_race", 5'd4);
    chk_rd("t5_stat_race", 2'd3, stat_word(2'd2, 5'd4));
    i_irq = 8'h00;

    // 6: asynchronous reset mid-service
    i_irq = 8'h80;
    tick(1);
    i_irq = 8'h00;
    tick(2);
    chk_rd("t6_pend_pre", 2'd0, 32'h0000_0080);
    i_rst_n = 1'b0;
    #1;
    chk_ext("t6_rst_ext", 1'b0);
    chk_id("t6_rst_id", 5'd0);
    chk_rd("t6_rst_pend", 2'd0, 32'd0);
    chk_rd("t6_rst_mask", 2'd1, 32'd0);
    chk_rd("t6_rst_stat", 2'd3, 32'd0);
    tick(1);
    i_rst_n = 1'b1;
    tick(1);

`ifdef INTC_LEVEL_EN
    // level-sensitive source re-sets one cycle after a clear
    i_irq = 8'h01;
    wr(2'd3, 32'h0000_0001);
    tick(3);
    chk_rd("lvl_pend_set", 2'd0, 32'h0000_0001);
    wr(2'd0, 32'h0000_0001);
    chk_rd("lvl_pend_clr", 2'd0, 32'd0);
    tick(1);
    chk_rd("lvl_pend_reset", 2'd0, 32'h0000_0001);
    i_irq = 8'h00;
`endif

    expect_v("scoreboard_drained", 32'd0);
    check_v(32'(exp_q.size() - 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
